// File: rtl/manual_drive_ctrl_pkg.sv
// Purpose : shared drive-state encodings and default timing constants for the
//           drive controller and the display/LED blocks that decode its state.
// Contents: drive_state_t enum (ST_OFF..ST_MOVING), CLK_PER_MS default.
package manual_drive_ctrl_pkg;

    // 100 MHz board clock -> 100000 clocks per 1 ms tick.
    localparam int CLK_PER_MS = 100000;

    typedef enum logic [1:0] {
        ST_OFF          = 2'b00,
        ST_NOT_STARTING = 2'b01,
        ST_STARTING     = 2'b10,
        ST_MOVING       = 2'b11
    } drive_state_t;

    // Display/LED helpers: same decode as the controller's outputs.
    function automatic logic state_is_powered(input drive_state_t s);
        return s != ST_OFF;
    endfunction

    function automatic logic state_is_moving(input drive_state_t s);
        return s == ST_MOVING;
    endfunction

endpackage

// File: rtl/manual_drive_ctrl_ms_tick_gen.sv
// Purpose : free-running ms prescaler; o_ms_tick pulses for one clk as the
//           count wraps from CLK_PER_MS-1 to 0.
// Ports   : clk, rst (sync, active-low), o_ms_tick (combinational decode of
//           the count register, high during the last clk of each ms).
module ms_tick_gen #(
    parameter int CLK_PER_MS = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic o_ms_tick
);

    localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_MS - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap    = (r_cnt == CNT_LAST);
    assign o_ms_tick = w_wrap;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/manual_drive_ctrl.sv
// Purpose : drive-train sequencer: hold-to-start ignition, throttle/clutch/
//           brake/reverse rules, mileage accumulation while MOVING.
// Ports   : clk, rst (sync active-low), power_on/power_off/throttle/clutch/
//           brake/reverse switch inputs; state, reverse_gear, mileage
//           registered outputs; powered/moving decoded from state.
module manual_drive_ctrl #(
    parameter int CLK_PER_MS = manual_drive_ctrl_pkg::CLK_PER_MS,
    parameter int HOLD_MS    = 1000,
    parameter int MILE_MS    = 1000,
    parameter int MILE_W     = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power_on,
    input  logic              power_off,
    input  logic              throttle,
    input  logic              clutch,
    input  logic              brake,
    input  logic              reverse,
    output logic [1:0]        state,
    output logic              powered,
    output logic              moving,
    output logic              reverse_gear,
    output logic [MILE_W-1:0] mileage
);

    import manual_drive_ctrl_pkg::*;

    localparam int HOLD_W = $clog2(HOLD_MS + 1);
    localparam int MCNT_W = $clog2(MILE_MS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MS - 1);
    localparam logic [MCNT_W-1:0] MILE_LAST = MCNT_W'(MILE_MS - 1);

    drive_state_t      r_state;
    drive_state_t      w_next;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [MCNT_W-1:0] r_mile_cnt;
    logic [MILE_W-1:0] r_mileage;
    logic              r_reverse_gear;
    logic              w_ms_tick;
    logic              w_hold_done;
    logic              w_enter_off;

    ms_tick_gen #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_ms_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .o_ms_tick (w_ms_tick)
    );

    // The tick that would bring hold_cnt to HOLD_MS completes the hold.
    assign w_hold_done = power_on && w_ms_tick && (r_hold_cnt == HOLD_LAST);

    always_comb begin
        w_next = r_state;
        if (r_state != ST_OFF && power_off) begin
            w_next = ST_OFF;
        end else begin
            unique case (r_state)
                ST_OFF: begin
                    if (w_hold_done) w_next = ST_NOT_STARTING;
                end
                ST_NOT_STARTING: begin
                    if (throttle && clutch) w_next = ST_STARTING;
                    else if (throttle)      w_next = ST_OFF;   // stall
                end
                ST_STARTING: begin
                    if (brake)                  w_next = ST_NOT_STARTING;
                    else if (throttle && !clutch) w_next = ST_MOVING;
                end
                ST_MOVING: begin
                    if (brake)
                        w_next = ST_NOT_STARTING;
                    else if ((reverse != r_reverse_gear) && !clutch)
                        w_next = ST_OFF;                        // gear grind
                    else if (clutch || !throttle)
                        w_next = ST_STARTING;
                end
                default: w_next = ST_OFF;
            endcase
        end
    end

    assign w_enter_off = (r_state != ST_OFF) && (w_next == ST_OFF);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= ST_OFF;
            r_hold_cnt     <= '0;
            r_mile_cnt     <= '0;
            r_mileage      <= '0;
            r_reverse_gear <= 1'b0;
        end else begin
            r_state <= w_next;

            // Hold counter only lives in OFF and needs an unbroken press.
            if (r_state != ST_OFF || !power_on) begin
                r_hold_cnt <= '0;
            end else if (w_ms_tick) begin
                r_hold_cnt <= (r_hold_cnt == HOLD_LAST) ? '0 : r_hold_cnt + 1'b1;
            end

            // While MOVING the gear only engages with the clutch down, so a
            // clutchless gear fault leaves the old gear latched.
            if (r_state != ST_MOVING || clutch) begin
                r_reverse_gear <= reverse;
            end

            // Partial ms of distance is kept across MOVING exits; a trip
            // ends only when the car is switched off.
            if (w_enter_off) begin
                r_mile_cnt <= '0;
                r_mileage  <= '0;
            end else if (r_state == ST_MOVING && w_ms_tick) begin
                if (r_mile_cnt == MILE_LAST) begin
                    r_mile_cnt <= '0;
                    if (r_mileage != {MILE_W{1'b1}}) begin
                        r_mileage <= r_mileage + 1'b1;
                    end
                end else begin
                    r_mile_cnt <= r_mile_cnt + 1'b1;
                end
            end
        end
    end

    assign state        = r_state;
    assign powered      = state_is_powered(r_state);
    assign moving       = state_is_moving(r_state);
    assign reverse_gear = r_reverse_gear;
    assign mileage      = r_mileage;

endmodule

// File: tb/tb_manual_drive_ctrl.sv
module tb_manual_drive_ctrl;

    logic        clk;
    logic        rst;
    logic        power_on, power_off, throttle, clutch, brake, reverse;
    logic [1:0]  state;
    logic        powered, moving, reverse_gear;
    logic [23:0] mileage;

    int n_tests = 0;
    int n_fail  = 0;

    manual_drive_ctrl #(
        .CLK_PER_MS (4),
        .HOLD_MS    (10),
        .MILE_MS    (5),
        .MILE_W     (24)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .power_on     (power_on),
        .power_off    (power_off),
        .throttle     (throttle),
        .clutch       (clutch),
        .brake        (brake),
        .reverse      (reverse),
        .state        (state),
        .powered      (powered),
        .moving       (moving),
        .reverse_gear (reverse_gear),
        .mileage      (mileage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; sample/drive 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        power_on = 0; power_off = 0; throttle = 0;
        clutch = 0; brake = 0; reverse = 0;
    endtask

    // Reset edge leaves the prescaler at 0, so ticks land on edges 4,8,12...
    task automatic do_reset(input logic hold_power);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        power_on = hold_power;
    endtask

    // After this the DUT has left OFF on edge 40 (10 ticks of power_on).
    task automatic ignite();
        do_reset(1'b1);
        step(40);
        power_on = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        step(2);
        n_tests++;
        if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b want 00", state); end
        n_tests++;
        if (powered !== 1'b0 || moving !== 1'b0) begin
            n_fail++; $display("FAIL reset_decode got powered=%b moving=%b want 0 0", powered, moving);
        end
        n_tests++;
        if (reverse_gear !== 1'b0 || mileage !== 24'd0) begin
            n_fail++; $display("FAIL reset_regs got rg=%b mileage=%0d want 0 0", reverse_gear, mileage);
        end
        rst = 1'b1;
    endtask

    task automatic test_ignition_full();
        clear_inputs();
        do_reset(1'b1);
        step(39);
        n_tests++;
        if (state !== 2'b00) begin n_fail++; $display("FAIL ign_full_edge39 got %b want 00", state); end
        step(1);
        n_tests++;
        if (state !== 2'b01 || powered !== 1'b1 || moving !== 1'b0) begin
            n_fail++; $display("FAIL ign_full_edge40 got state=%b powered=%b moving=%b want 01 1 0", state, powered, moving);
        end
        // power_on while already powered is ignored.
        step(45);
        n_tests++;
        if (state !== 2'b01) begin n_fail++; $display("FAIL ign_repress got %b want 01", state); end
        power_on = 0;
    endtask

    task automatic test_ignition_interrupted();
        clear_inputs();
        do_reset(1'b1);
        step(36);               // 9 ticks
        power_on = 0;
        step(1);                // edge 37 clears hold
        power_on = 1;
        step(38);               // edge 75: 9 further ticks (40..72)
        n_tests++;
        if (state !== 2'b00) begin n_fail++; $display("FAIL ign_int_edge75 got %b want 00", state); end
        step(1);                // edge 76: 10th further tick
        n_tests++;
        if (state !== 2'b01) begin n_fail++; $display("FAIL ign_int_edge76 got %b want 01", state); end
        power_on = 0;
    endtask

    task automatic test_start_sequence();
        // Stall from NOT_STARTING.
        throttle = 1; clutch = 0;
        step(1);
        n_tests++;
        if (state !== 2'b00) begin n_fail++; $display("FAIL stall got %b want 00", state); end
        clear_inputs();
        ignite();
        throttle = 1; clutch = 1;
        step(1);
        n_tests++;
        if (state !== 2'b10) begin n_fail++; $display("FAIL to_starting got %b want 10", state); end
        clutch = 0;
        step(1);
        n_tests++;
        if (state !== 2'b11 || moving !== 1'b1 || powered !== 1'b1) begin
            n_fail++; $display("FAIL to_moving got state=%b moving=%b powered=%b want 11 1 1", state, moving, powered);
        end
        clear_inputs();
    endtask

    task automatic test_mileage();
        clear_inputs();
        ignite();
        throttle = 1; clutch = 1;
        step(1);                // edge 41 STARTING
        clutch = 0;
        step(1);                // edge 42 MOVING
        step(18);               // edge 60: 5th tick in MOVING
        n_tests++;
        if (mileage !== 24'd1) begin n_fail++; $display("FAIL mileage_first got %0d want 1", mileage); end
        step(42);               // edge 102: 15 ticks total
        n_tests++;
        if (mileage !== 24'd3 || state !== 2'b11) begin
            n_fail++; $display("FAIL mileage_15ticks got mileage=%0d state=%b want 3 11", mileage, state);
        end
        brake = 1;
        step(1);
        n_tests++;
        if (state !== 2'b01 || mileage !== 24'd3) begin
            n_fail++; $display("FAIL brake_keep got state=%b mileage=%0d want 01 3", state, mileage);
        end
        brake = 0; throttle = 0; power_off = 1;
        step(1);
        n_tests++;
        if (state !== 2'b00 || mileage !== 24'd0) begin
            n_fail++; $display("FAIL poweroff_clear got state=%b mileage=%0d want 00 0", state, mileage);
        end
        clear_inputs();
    endtask

    task automatic test_gear_change();
        clear_inputs();
        ignite();
        throttle = 1; clutch = 1;
        step(1);
        clutch = 0;
        step(1);
        reverse = 1;            // no clutch: gear fault
        step(1);
        n_tests++;
        if (state !== 2'b00 || reverse_gear !== 1'b0) begin
            n_fail++; $display("FAIL gear_fault got state=%b rg=%b want 00 0", state, reverse_gear);
        end
        clear_inputs();
        ignite();
        throttle = 1; clutch = 1;
        step(1);
        clutch = 0;
        step(1);
        clutch = 1; reverse = 1;
        step(1);
        n_tests++;
        if (state !== 2'b10 || reverse_gear !== 1'b1) begin
            n_fail++; $display("FAIL gear_clutch got state=%b rg=%b want 10 1", state, reverse_gear);
        end
        clear_inputs();
    endtask

    task automatic test_priorities_and_reset();
        clear_inputs();
        ignite();
        throttle = 1; clutch = 1;
        step(1);
        throttle = 0; clutch = 0;
        power_off = 1; brake = 1;
        step(1);
        n_tests++;
        if (state !== 2'b00) begin n_fail++; $display("FAIL off_beats_brake got %b want 00", state); end
        clear_inputs();
        reverse = 1;
        ignite();
        throttle = 1; clutch = 1;
        step(1);
        clutch = 0;
        step(1);                // edge 42 MOVING
        step(43);               // edge 85: 11 ticks -> mileage 2
        n_tests++;
        if (state !== 2'b11 || mileage !== 24'd2 || reverse_gear !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset got state=%b mileage=%0d rg=%b want 11 2 1", state, mileage, reverse_gear);
        end
        rst = 0;
        step(1);
        rst = 1;
        n_tests++;
        if (state !== 2'b00 || mileage !== 24'd0 || reverse_gear !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got state=%b mileage=%0d rg=%b want 00 0 0", state, mileage, reverse_gear);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_ignition_full();
        test_ignition_interrupted();
        test_start_sequence();
        test_mileage();
        test_gear_change();
        test_priorities_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/manual_drive_ctrl.md
Name: manual_drive_ctrl

Overview:
Top-level sequencer for the car's engine and manual drive train. It owns the four-state drive FSM: OFF, NOT_STARTING, STARTING, MOVING.
- Implements the 1 s hold-to-start ignition internally.
- Applies throttle, clutch, brake and reverse rules.
- Accumulates mileage while MOVING.
- Feeds the display and LED blocks.

Parameters:
CLK_PER_MS, 100000, system clocks per 1 ms tick (100 MHz board clock)
HOLD_MS, 1000, ms power_on must be held continuously to leave OFF
MILE_MS, 1000, ms of MOVING per mileage increment
MILE_W, 24, mileage counter width

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-low (asserted when 0)
power_on  input  1  debounced ignition button, level
power_off  input  1  debounced kill button, level
throttle  input  1  throttle switch
clutch  input  1  clutch switch
brake  input  1  brake switch
reverse  input  1  gear switch (1 = reverse)
state  output  2  00 OFF, 01 NOT_STARTING, 10 STARTING, 11 MOVING
powered  output  1  state != OFF
moving  output  1  state == MOVING
reverse_gear  output  1  latched gear actually engaged
mileage  output  MILE_W  distance units travelled since last power-up

Behaviour:
- All logic is clocked on posedge clk. `rst` is sampled only on clk edges; rst==0 is the reset condition.
- Reset values: state=OFF, reverse_gear=0, mileage=0, all internal counters 0.
- ms prescaler:
  - Counts 0..CLK_PER_MS-1 and wraps.
  - ms_tick is a one-cycle pulse when the count wraps.
  - The prescaler free-runs in every state.
- Ignition hold (OFF only):
  - hold_cnt increments on each ms_tick while power_on==1.
  - Any cycle with power_on==0 clears hold_cnt.
  - When the ms_tick increment brings hold_cnt to HOLD_MS: state<=NOT_STARTING and hold_cnt<=0.
  - hold_cnt is forced to 0 outside OFF.
- Transitions are evaluated every clk cycle, registered, and take effect next cycle. Priority is highest first:
  1. power_off==1 in any powered state -> OFF.
  2. NOT_STARTING:
     - throttle & clutch -> STARTING.
     - throttle & ~clutch -> OFF (stall).
     - otherwise stay.
  3. STARTING:
     - brake -> NOT_STARTING (brake beats throttle).
     - throttle & ~clutch -> MOVING.
     - otherwise stay.
  4. MOVING:
     - brake -> NOT_STARTING.
     - (reverse != reverse_gear) & ~clutch -> OFF (gear change without clutch).
     - clutch | ~throttle -> STARTING.
     - otherwise stay.
- power_on while already powered has no effect. power_off in OFF has no effect and does not block hold counting unless power_on drops.
- reverse_gear:
  - Loads `reverse` every cycle in OFF, NOT_STARTING and STARTING.
  - In MOVING it loads only when clutch==1.
  - On the MOVING->OFF gear-fault transition it keeps its old value.
- Mileage:
  - mile_cnt counts ms_ticks while in MOVING.
  - When mile_cnt reaches MILE_MS: mileage<=mileage+1 and mile_cnt<=0.
  - mileage saturates at all-ones and does not wrap.
  - mile_cnt holds when leaving MOVING and resumes on re-entry.
  - mileage and mile_cnt clear on every entry to OFF.
- Outputs:
  - state, reverse_gear and mileage are registers.
  - powered and moving are decoded combinationally from state.
- Reset mid-operation: reset overrides everything in that cycle and returns to OFF with counters cleared.

Decomposition:
- Shared package/header holds the state encodings (ST_OFF, ST_NOT_STARTING, ST_STARTING, ST_MOVING) and CLK_PER_MS. The display and LED blocks decode `state` using the same constants.
- One sub-module, ms_tick_gen: prescaler with CLK_PER_MS parameter and synchronous active-low `rst`, producing the ms_tick pulse. The FSM and counters stay in manual_drive_ctrl.

Test Plan:
All scenarios use CLK_PER_MS=4, HOLD_MS=10, MILE_MS=5.
1. Ignition hold, full: hold power_on from reset -> state leaves OFF exactly on the clk after the 10th ms_tick (~40 clks); state=01, powered=1.
2. Ignition hold, interrupted: release power_on after 9 ticks, then re-hold -> hold_cnt restarts and 10 further ticks are required.
3. Stall and start-up: in NOT_STARTING, throttle=1, clutch=0 -> state=00 next cycle.
   - Repeat with clutch=1 -> state=10.
   - Then clutch=0, throttle=1 -> state=11.
4. Mileage: hold MOVING for 60 clks (15 ticks) -> mileage=3.
   - Brake -> state=01, and mileage stays 3.
   - power_off -> state=00, mileage=0.
5. Gear change while MOVING:
   - Toggle reverse with clutch=0 -> state=00 next cycle, reverse_gear unchanged.
   - From MOVING with clutch=1 and reverse toggled -> reverse_gear flips and state=10.
6. Priorities and reset:
   - power_off and brake asserted in the same cycle in STARTING -> OFF.
   - rst=0 for one clk while MOVING with mileage=2 -> state=00, mileage=0, reverse_gear=0 on the following edge.
